fb_scanout_arbiter: RTL and testbench
=====================================

# fb_scanout_arbiter

Shares one single-port RGB565 framebuffer RAM (160x120 words, shown 4x4-upscaled on the 640x480 raster) between the display path and a host writer. When the display timing requests a framebuffer row, the block streams that row into the scanout line buffer. Between fetches it services single-word host writes through a req/ack handshake. It sits between the framebuffer RAM, the line buffer feeding the VGA pixel output, and the host bus bridge.

## Interface
- FB_W, 160: framebuffer pixels per row (words fetched per line_req)
- FB_H, 120: framebuffer rows
- FB_WORDS, 19200: FB_W*FB_H; valid host address range 0..FB_WORDS-1
- clk25  in  1  25 MHz pixel clock
- reset  in  1  asynchronous, active-high
- line_req  in  1  one-cycle pulse requesting a row fetch
- line_row  in  7  framebuffer row for line_req, sampled with it
- host_req  in  1  host write request; held with addr/data until ack
- host_addr  in  15  word address
- host_data  in  16  RGB565 pixel
- host_ack  out  1  one-cycle pulse; write accepted
- ram_en  out  1  RAM access strobe
- ram_we  out  1  1 = write, 0 = read
- ram_addr  out  15  RAM word address
- ram_wdata  out  16  RAM write data
- ram_rdata  in  16  RAM read data, valid the cycle after a read strobe
- lb_we  out  1  line-buffer write strobe
- lb_addr  out  8  line-buffer index 0..FB_W-1
- lb_data  out  16  line-buffer write data
- fetch_busy  out  1  high while a row fetch is in progress
- fetch_done  out  1  one-cycle pulse on the last line-buffer write of a fetch
- fetch_overrun  out  1  sticky; line_req arrived while a fetch was busy or pending

## Operation
- All outputs are registered. After reset, every output is 0, the FSM is in IDLE, and the pending fetch and overrun flags are clear.
- FSM states:
  - IDLE: select the next operation.
  - FETCH: issue the FB_W reads.
  - DRAIN: write the last read's data to the line buffer.
  - HOST: issue one write.
- Pending fetch: line_req with line_row < FB_H sets pend and latches the row. line_row >= FB_H is ignored, with no fetch and no flag.
- If line_req arrives while fetch_busy=1 or pend=1:
  - fetch_overrun is set and stays set until reset.
  - The new row overwrites the pending row.
  - The current fetch continues unaffected.
- IDLE priority is fetch first, then host. A line_req in the same cycle as host_req wins; the host waits.
- FETCH:
  - Read index i runs 0..FB_W-1, one read per cycle, with ram_en=1, ram_we=0, ram_addr=row*FB_W+i.
  - Address arithmetic is done at 15 bits; the maximum is 19199, so it never overflows.
  - After i=FB_W-1, go to DRAIN.
- Line-buffer writes: each cycle after a read strobe, lb_we=1, lb_addr=i of that read, lb_data=ram_rdata. This pipeline runs through FETCH and DRAIN.
- DRAIN: issue the final lb write and pulse fetch_done, then go to IDLE. If pend was set again meanwhile, the next fetch starts from IDLE.
- HOST:
  - If host_addr < FB_WORDS: ram_en=1, ram_we=1, ram_addr=host_addr, ram_wdata=host_data.
  - If host_addr >= FB_WORDS: ram_en=0 and the write is dropped silently.
  - In both cases host_ack=1 for one cycle, then go to IDLE.
- Host rules:
  - The host keeps req/addr/data stable until it samples ack=1.
  - host_req still high in the cycle after ack counts as a new write.
  - Host requests are never dropped, only delayed.
- Reset mid-fetch or mid-host-write aborts immediately. No further RAM or line-buffer strobes are issued, and pend and overrun are cleared.

## Timing
- Fetch latency: line_req high in cycle T with the FSM in IDLE gives:
  - ram_en for i=0 at T+1 and for i=159 at T+160.
  - lb_we at T+2..T+161, contiguous.
  - fetch_done at T+161.
  - fetch_busy high T+1..T+161.
  - IDLE at T+162.
- A line_req arriving while in HOST is latched, and its fetch starts 2 cycles after the host write cycle.
- Host write latency: host_req sampled in IDLE at cycle T gives ram_en/ram_we and host_ack both at T+1, and IDLE again at T+2.
- Back-to-back host writes therefore run 1 per 2 cycles.
- Worst-case host wait is one full fetch: 163 cycles. This fits inside the 800-cycle line period.
- ram_en is never asserted twice in the same cycle. ram_we=1 never occurs while fetch_busy=1.

## Test plan
- Reset, then line_req with line_row=5 at T: 160 reads at addresses 800..959 (T+1..T+160); lb_we at T+2..T+161 with lb_addr 0..159 and lb_data matching a RAM model preloaded with the address as data; fetch_done at T+161.
- host_req with addr=0x0123, data=0xF800 in IDLE: ram_we=1, addr 0x0123, wdata 0xF800, and host_ack all in the same cycle. Host holds req for 3 more writes: acks arrive every 2 cycles.
- host_req and line_req in the same cycle: the fetch runs first, and host_ack arrives 2 cycles after fetch_done with the correct write.
- Second line_req (row 7) mid-fetch of row 6: fetch_overrun=1; row 6 completes, then row 7 is fetched (addresses 1120..1279). line_row=120: no RAM activity.
- host_addr=19200: host_ack pulses, ram_en stays 0. host_addr=19199 is written normally.
- Assert reset at i=80 of a fetch: all strobes are 0 on the next sample, pend and overrun are cleared, and a line_req after release fetches from i=0.

Source files
------------

// File: rtl/fb_scanout_arbiter.sv
// Framebuffer RAM arbiter: streams requested 160-word rows into the scanout line
// buffer and services single-word host writes in the gaps between fetches.
module fb_scanout_arbiter #(
    parameter int FB_W     = 160,
    parameter int FB_H     = 120,
    parameter int FB_WORDS = FB_W * FB_H
) (
    input  logic        clk25,
    input  logic        reset,
    input  logic        line_req_i,
    input  logic [6:0]  line_row_i,
    input  logic        host_req_i,
    input  logic [14:0] host_addr_i,
    input  logic [15:0] host_data_i,
    output logic        host_ack_o,
    output logic        ram_en_o,
    output logic        ram_we_o,
    output logic [14:0] ram_addr_o,
    output logic [15:0] ram_wdata_o,
    input  logic [15:0] ram_rdata_i,
    output logic        lb_we_o,
    output logic [7:0]  lb_addr_o,
    output logic [15:0] lb_data_o,
    output logic        fetch_busy_o,
    output logic        fetch_done_o,
    output logic        fetch_overrun_o
);

    localparam logic [6:0]  FB_H_L     = 7'(FB_H);
    localparam logic [14:0] FB_WORDS_L = 15'(FB_WORDS);
    localparam logic [7:0]  LAST_IDX   = 8'(FB_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_HOST  = 2'd3
    } state_t;

    function automatic logic [14:0] row_base(input logic [6:0] row);
        row_base = 15'(row) * 15'(FB_W);
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [14:0] base_q, base_d;
    logic        pend_q, pend_d;
    logic [6:0]  pend_row_q, pend_row_d;
    logic        overrun_q, overrun_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ack_q, ack_d;
    logic        ram_en_q, ram_en_d;
    logic        ram_we_q, ram_we_d;
    logic [14:0] ram_addr_q, ram_addr_d;
    logic [15:0] ram_wdata_q, ram_wdata_d;
    logic        lb_we_q, lb_we_d;
    logic [7:0]  lb_addr_q, lb_addr_d;

    logic        line_ok_s;
    logic [6:0]  start_row_s;
    logic [7:0]  idx_nxt_s;
    logic        host_in_range_s;

    assign line_ok_s       = line_req_i & (line_row_i < FB_H_L);
    assign start_row_s     = line_ok_s ? line_row_i : pend_row_q;
    assign idx_nxt_s       = idx_q + 8'd1;
    assign host_in_range_s = host_addr_i < FB_WORDS_L;

    // Next-state, request bookkeeping and next value of every registered output.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        base_d      = base_q;
        pend_d      = pend_q;
        pend_row_d  = pend_row_q;
        overrun_d   = overrun_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ack_d       = 1'b0;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        // Each read strobe turns into a line-buffer write one cycle later.
        lb_we_d     = ram_en_q & ~ram_we_q;
        lb_addr_d   = idx_q;

        if (line_ok_s && (busy_q || pend_q)) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        if (line_ok_s) begin
            pend_d     = 1'b1;
            pend_row_d = line_row_i;
        end else begin
            pend_d     = pend_q;
            pend_row_d = pend_row_q;
        end

        case (state_q)
            S_IDLE: begin
                if (line_ok_s || pend_q) begin
                    state_d    = S_FETCH;
                    pend_d     = 1'b0;
                    busy_d     = 1'b1;
                    idx_d      = 8'd0;
                    base_d     = row_base(start_row_s);
                    ram_en_d   = 1'b1;
                    ram_addr_d = row_base(start_row_s);
                end else if (host_req_i) begin
                    // Out-of-range writes are acknowledged but never reach the RAM.
                    state_d     = S_HOST;
                    ack_d       = 1'b1;
                    ram_en_d    = host_in_range_s;
                    ram_we_d    = host_in_range_s;
                    ram_addr_d  = host_addr_i;
                    ram_wdata_d = host_data_i;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DRAIN;
                    done_d  = 1'b1;
                end else begin
                    idx_d      = idx_nxt_s;
                    ram_en_d   = 1'b1;
                    ram_addr_d = base_q + {7'd0, idx_nxt_s};
                end
            end
            S_DRAIN: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            S_HOST: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= 8'd0;
            base_q      <= 15'd0;
            pend_q      <= 1'b0;
            pend_row_q  <= 7'd0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ack_q       <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= 15'd0;
            ram_wdata_q <= 16'd0;
            lb_we_q     <= 1'b0;
            lb_addr_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            base_q      <= base_d;
            pend_q      <= pend_d;
            pend_row_q  <= pend_row_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ack_q       <= ack_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            lb_we_q     <= lb_we_d;
            lb_addr_q   <= lb_addr_d;
        end
    end

    assign host_ack_o      = ack_q;
    assign ram_en_o        = ram_en_q;
    assign ram_we_o        = ram_we_q;
    assign ram_addr_o      = ram_addr_q;
    assign ram_wdata_o     = ram_wdata_q;
    assign lb_we_o         = lb_we_q;
    assign lb_addr_o       = lb_addr_q;
    assign fetch_busy_o    = busy_q;
    assign fetch_done_o    = done_q;
    assign fetch_overrun_o = overrun_q;
    // The RAM's read register already times the data; it is gated so it reads 0 when idle.
    assign lb_data_o       = lb_we_q ? ram_rdata_i : 16'd0;

endmodule

// File: tb/tb_fb_scanout_arbiter.sv
// Scoreboard bench for fb_scanout_arbiter: stimulus pushes timestamped expected
// events per channel, a negedge monitor pops and compares whatever the DUT emits.
module tb_fb_scanout_arbiter;

    typedef struct {
        int c;
        int a;
        int d;
    } ev_t;

    logic        clk25;
    logic        reset;
    logic        line_req;
    logic [6:0]  line_row;
    logic        host_req;
    logic [14:0] host_addr;
    logic [15:0] host_data;
    logic        host_ack;
    logic        ram_en;
    logic        ram_we;
    logic [14:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        lb_we;
    logic [7:0]  lb_addr;
    logic [15:0] lb_data;
    logic        fetch_busy;
    logic        fetch_done;
    logic        fetch_overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t;

    logic [15:0] mem     [19200];
    logic [15:0] exp_mem [19200];
    logic [15:0] hd      [4];

    ev_t exp_rd[$];
    ev_t exp_wr[$];
    ev_t exp_lb[$];
    ev_t exp_ack[$];
    ev_t exp_done[$];

    fb_scanout_arbiter dut (
        .clk25           (clk25),
        .reset           (reset),
        .line_req_i      (line_req),
        .line_row_i      (line_row),
        .host_req_i      (host_req),
        .host_addr_i     (host_addr),
        .host_data_i     (host_data),
        .host_ack_o      (host_ack),
        .ram_en_o        (ram_en),
        .ram_we_o        (ram_we),
        .ram_addr_o      (ram_addr),
        .ram_wdata_o     (ram_wdata),
        .ram_rdata_i     (ram_rdata),
        .lb_we_o         (lb_we),
        .lb_addr_o       (lb_addr),
        .lb_data_o       (lb_data),
        .fetch_busy_o    (fetch_busy),
        .fetch_done_o    (fetch_done),
        .fetch_overrun_o (fetch_overrun)
    );

    initial clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    always @(posedge clk25) cyc <= cyc + 1;

    // Synchronous single-port RAM model, read data one cycle after the strobe.
    always @(posedge clk25) begin
        if (ram_en && (int'(ram_addr) < 19200)) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d: unexpected strobe", nm, cyc);
    endtask

    // Monitor: every strobe the DUT presents must match the next queued event.
    always @(negedge clk25) begin
        ev_t e;
        if (ram_en && !ram_we) begin
            if (exp_rd.size() == 0) unexpected("ram_rd");
            else begin
                e = exp_rd.pop_front();
                chk("rd_cycle", cyc, e.c);
                chk("rd_addr", {17'd0, ram_addr}, e.a);
            end
        end
        if (ram_en && ram_we) begin
            chk("wr_while_busy", {31'd0, fetch_busy}, 32'd0);
            if (exp_wr.size() == 0) unexpected("ram_wr");
            else begin
                e = exp_wr.pop_front();
                chk("wr_cycle", cyc, e.c);
                chk("wr_addr", {17'd0, ram_addr}, e.a);
                chk("wr_data", {16'd0, ram_wdata}, e.d);
            end
        end
        if (lb_we) begin
            if (exp_lb.size() == 0) unexpected("lb_we");
            else begin
                e = exp_lb.pop_front();
                chk("lb_cycle", cyc, e.c);
                chk("lb_addr", {24'd0, lb_addr}, e.a);
                chk("lb_data", {16'd0, lb_data}, e.d);
            end
        end
        if (host_ack) begin
            if (exp_ack.size() == 0) unexpected("host_ack");
            else begin
                e = exp_ack.pop_front();
                chk("ack_cycle", cyc, e.c);
            end
        end
        if (fetch_done) begin
            if (exp_done.size() == 0) unexpected("fetch_done");
            else begin
                e = exp_done.pop_front();
                chk("done_cycle", cyc, e.c);
            end
        end
    end

    task automatic step();
        @(posedge clk25);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic push_fetch(input int t0, input int row, input int nrd, input int nlb, input bit dn);
        for (int i = 0; i < nrd; i++) exp_rd.push_back('{t0 + 1 + i, row * 160 + i, 0});
        for (int i = 0; i < nlb; i++) exp_lb.push_back('{t0 + 2 + i, i, int'(exp_mem[row * 160 + i])});
        if (dn) exp_done.push_back('{t0 + 161, 0, 0});
    endtask

    task automatic push_host(input int tack, input int addr, input int data);
        exp_ack.push_back('{tack, 0, 0});
        if (addr < 19200) begin
            exp_wr.push_back('{tack, addr, data});
            exp_mem[addr] = 16'(data);
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 19200; i++) begin
            mem[i]     = 16'(i);
            exp_mem[i] = 16'(i);
        end
        hd[0] = 16'hF800; hd[1] = 16'h07E0; hd[2] = 16'h001F; hd[3] = 16'hFFFF;
        reset = 1'b1; line_req = 1'b0; line_row = 7'd0;
        host_req = 1'b0; host_addr = 15'd0; host_data = 16'd0;
        repeat (3) step();
        chk("rst_ack", {31'd0, host_ack}, 32'd0);
        chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_ram_addr", {17'd0, ram_addr}, 32'd0);
        chk("rst_lb_we", {31'd0, lb_we}, 32'd0);
        chk("rst_lb_data", {16'd0, lb_data}, 32'd0);
        chk("rst_busy", {31'd0, fetch_busy}, 32'd0);
        chk("rst_done", {31'd0, fetch_done}, 32'd0);
        chk("rst_overrun", {31'd0, fetch_overrun}, 32'd0);
        reset = 1'b0;
        step(); step();

        // Row 5 fetch: reads 800..959.
        line_req = 1'b1; line_row = 7'd5; t = cyc;
        push_fetch(t, 5, 160, 160, 1'b1);
        step(); line_req = 1'b0;
        chk("busy_first", {31'd0, fetch_busy}, 32'd1);
        wait_to(t + 161);
        chk("busy_last", {31'd0, fetch_busy}, 32'd1);
        chk("done_pulse", {31'd0, fetch_done}, 32'd1);
        wait_to(t + 162);
        chk("busy_clear", {31'd0, fetch_busy}, 32'd0);
        step();

        // Host burst: four writes, one ack every two cycles.
        host_req = 1'b1; t = cyc;
        for (int k = 0; k < 4; k++) begin
            host_addr = 15'h0123 + 15'(k);
            host_data = hd[k];
            push_host(t + 1 + 2 * k, 32'h123 + k, int'(hd[k]));
            wait_to(t + 1 + 2 * k);
            chk("burst_ack", {31'd0, host_ack}, 32'd1);
        end
        host_req = 1'b0;
        step(); step();

        // Row 1 holds the burst addresses; lb data must show the written pixels.
        line_req = 1'b1; line_row = 7'd1; t = cyc;
        push_fetch(t, 1, 160, 160, 1'b1);
        step(); line_req = 1'b0;
        wait_to(t + 163);

        // Simultaneous line_req and host_req: fetch first, ack 2 cycles after done.
        host_req = 1'b1; host_addr = 15'h2000; host_data = 16'h1234;
        line_req = 1'b1; line_row = 7'd2; t = cyc;
        push_fetch(t, 2, 160, 160, 1'b1);
        push_host(t + 163, 32'h2000, 32'h1234);
        step(); line_req = 1'b0;
        wait_to(t + 163);
        chk("tie_ack", {31'd0, host_ack}, 32'd1);
        host_req = 1'b0;
        step(); step();

        // Row 120 is out of range: no fetch, no overrun.
        line_req = 1'b1; line_row = 7'd120; t = cyc;
        step(); line_req = 1'b0;
        wait_to(t + 3);
        chk("bad_row_busy", {31'd0, fetch_busy}, 32'd0);
        chk("bad_row_overrun", {31'd0, fetch_overrun}, 32'd0);

        // Row 7 requested mid-fetch of row 6.
        line_req = 1'b1; line_row = 7'd6; t = cyc;
        push_fetch(t, 6, 160, 160, 1'b1);
        step(); line_req = 1'b0;
        wait_to(t + 50);
        chk("overrun_before", {31'd0, fetch_overrun}, 32'd0);
        line_req = 1'b1; line_row = 7'd7;
        push_fetch(t + 162, 7, 160, 160, 1'b1);
        step(); line_req = 1'b0;
        chk("overrun_set", {31'd0, fetch_overrun}, 32'd1);
        wait_to(t + 60);
        line_req = 1'b1; line_row = 7'd120;
        step(); line_req = 1'b0;
        wait_to(t + 325);
        chk("overrun_sticky", {31'd0, fetch_overrun}, 32'd1);
        chk("busy_after_two", {31'd0, fetch_busy}, 32'd0);

        // Address boundary: 19200 dropped, 19199 written.
        host_req = 1'b1; host_addr = 15'd19200; host_data = 16'hAAAA; t = cyc;
        push_host(t + 1, 19200, 32'hAAAA);
        wait_to(t + 1);
        chk("oob_ram_en", {31'd0, ram_en}, 32'd0);
        chk("oob_ack", {31'd0, host_ack}, 32'd1);
        host_addr = 15'd19199; host_data = 16'h5555;
        push_host(t + 3, 19199, 32'h5555);
        wait_to(t + 3);
        chk("top_ack", {31'd0, host_ack}, 32'd1);
        host_req = 1'b0;
        step(); step();

        // Reset at read index 80 with a pending, overrun request.
        line_req = 1'b1; line_row = 7'd9; t = cyc;
        push_fetch(t, 9, 80, 79, 1'b0);
        step(); line_req = 1'b0;
        wait_to(t + 40);
        line_req = 1'b1; line_row = 7'd10;
        step(); line_req = 1'b0;
        chk("pre_rst_overrun", {31'd0, fetch_overrun}, 32'd1);
        wait_to(t + 81);
        reset = 1'b1;
        @(negedge clk25);
        chk("mid_rst_ram_en", {31'd0, ram_en}, 32'd0);
        chk("mid_rst_lb_we", {31'd0, lb_we}, 32'd0);
        chk("mid_rst_busy", {31'd0, fetch_busy}, 32'd0);
        chk("mid_rst_overrun", {31'd0, fetch_overrun}, 32'd0);
        step(); step();
        reset = 1'b0;
        repeat (4) step();
        chk("post_rst_busy", {31'd0, fetch_busy}, 32'd0);
        line_req = 1'b1; line_row = 7'd11; t = cyc;
        push_fetch(t, 11, 160, 160, 1'b1);
        step(); line_req = 1'b0;
        wait_to(t + 166);

        chk("left_rd", exp_rd.size(), 32'd0);
        chk("left_wr", exp_wr.size(), 32'd0);
        chk("left_lb", exp_lb.size(), 32'd0);
        chk("left_ack", exp_ack.size(), 32'd0);
        chk("left_done", exp_done.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
